// File: rtl/pc_pkg.sv
// Shared types and constants for the IF-stage next-PC logic.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ     = 3'd0,
    SRC_ID_JUMP = 3'd1,
    SRC_RAS     = 3'd2,
    SRC_EX      = 3'd3,
    SRC_TRAP    = 3'd4
  } pc_src_e;

  localparam int unsigned ILEN_STEP_16 = 32'd2;
  localparam int unsigned ILEN_STEP_32 = 32'd4;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return address stack with a saturating occupancy count.
// A full push overwrites the oldest entry; push+pop together swaps the top entry.
module return_addr_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_tos;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic [PTR_W-1:0] w_tos_inc;
  logic [PTR_W-1:0] w_tos_dec;

  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
  assign w_tos_inc = r_tos + PTR_W'(1);
  assign w_tos_dec = r_tos - PTR_W'(1);

  // Stack state update; a swap on an empty stack degrades to a plain push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tos   <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= {XLEN{1'b0}};
      end
    end else if (i_push && i_pop && !w_empty) begin
      r_mem[r_tos] <= i_data;
    end else if (i_push) begin
      r_mem[w_tos_inc] <= i_data;
      r_tos            <= w_tos_inc;
      if (!w_full) begin
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_count <= r_count;
      end
    end else if (i_pop && !w_empty) begin
      r_tos   <= w_tos_dec;
      r_count <= r_count - CNT_W'(1);
    end else begin
      r_tos   <= r_tos;
      r_count <= r_count;
    end
  end

  assign o_top   = r_mem[r_tos];
  assign o_empty = w_empty;

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage next-PC generator: sequential 2/4-byte advance or prioritised redirect
// (trap > EX > ID jump > RAS return), with link address and flush strobes.
module fetch_pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter bit              COMPRESSED   = 1'b1,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallIF,
  input  logic            isCompressedIF,
  input  logic            trapValid,
  input  logic [XLEN-1:0] trapTarget,
  input  logic            exRedirect,
  input  logic [XLEN-1:0] exTarget,
  input  logic            idValid,
  input  logic            idJump,
  input  logic [XLEN-1:0] idJumpTarget,
  input  logic            idCall,
  input  logic            idRet,
  input  logic [XLEN-1:0] idLinkAddr,
  output logic [XLEN-1:0] pcIF,
  output logic [XLEN-1:0] pcLink,
  output logic            flushIF,
  output logic            flushID,
  output logic            rasPredict
);

  localparam logic [XLEN-1:0] ALIGN_MASK = COMPRESSED ? XLEN'(1) : XLEN'(3);

  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
    return t & ~ALIGN_MASK;
  endfunction

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_step;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_id_ok;
  logic            w_push;
  logic            w_pop;
  logic            w_ras_hit;
  pc_src_e         w_src;

  assign w_step  = (COMPRESSED && isCompressedIF) ? XLEN'(ILEN_STEP_16) : XLEN'(ILEN_STEP_32);
  // Older-stage redirects void whatever ID is doing, including RAS updates.
  assign w_id_ok = idValid && !trapValid && !exRedirect;
  assign w_push  = w_id_ok && idCall;
  assign w_pop   = w_id_ok && idRet;

  if (RAS_DEPTH > 0) begin : g_ras
    return_addr_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (idLinkAddr),
      .o_top   (w_ras_top),
      .o_empty (w_ras_empty)
    );
  end else begin : g_no_ras
    assign w_ras_top   = {XLEN{1'b0}};
    assign w_ras_empty = 1'b1;
  end

  assign w_ras_hit = w_pop && !w_ras_empty;

  // Redirect source priority and next-PC selection.
  always_comb begin
    w_src     = SRC_SEQ;
    w_target  = {XLEN{1'b0}};
    w_next_pc = r_pc;
    if (trapValid) begin
      w_src = SRC_TRAP;
    end else if (exRedirect) begin
      w_src = SRC_EX;
    end else if (w_id_ok && idJump) begin
      w_src = SRC_ID_JUMP;
    end else if (w_ras_hit) begin
      w_src = SRC_RAS;
    end else begin
      w_src = SRC_SEQ;
    end
    case (w_src)
      SRC_TRAP:    w_target = trapTarget;
      SRC_EX:      w_target = exTarget;
      SRC_ID_JUMP: w_target = idJumpTarget;
      SRC_RAS:     w_target = w_ras_top;
      default:     w_target = {XLEN{1'b0}};
    endcase
    if (w_src != SRC_SEQ) begin
      w_next_pc = align_target(w_target);
    end else if (!stallIF) begin
      w_next_pc = r_pc + w_step;
    end else begin
      w_next_pc = r_pc;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign pcIF       = r_pc;
  assign pcLink     = r_pc + w_step;
  assign flushIF    = !rst && (w_src != SRC_SEQ);
  assign flushID    = !rst && ((w_src == SRC_TRAP) || (w_src == SRC_EX));
  assign rasPredict = !rst && (w_src == SRC_RAS);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with hand-computed expected values.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallIF;
  logic        isCompressedIF;
  logic        trapValid;
  logic [31:0] trapTarget;
  logic        exRedirect;
  logic [31:0] exTarget;
  logic        idValid;
  logic        idJump;
  logic [31:0] idJumpTarget;
  logic        idCall;
  logic        idRet;
  logic [31:0] idLinkAddr;
  logic [31:0] pcIF;
  logic [31:0] pcLink;
  logic        flushIF;
  logic        flushID;
  logic        rasPredict;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .COMPRESSED   (1'b1),
    .RAS_DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallIF        (stallIF),
    .isCompressedIF (isCompressedIF),
    .trapValid      (trapValid),
    .trapTarget     (trapTarget),
    .exRedirect     (exRedirect),
    .exTarget       (exTarget),
    .idValid        (idValid),
    .idJump         (idJump),
    .idJumpTarget   (idJumpTarget),
    .idCall         (idCall),
    .idRet          (idRet),
    .idLinkAddr     (idLinkAddr),
    .pcIF           (pcIF),
    .pcLink         (pcLink),
    .flushIF        (flushIF),
    .flushID        (flushID),
    .rasPredict     (rasPredict)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stallIF        = 1'b0;
    isCompressedIF = 1'b0;
    trapValid      = 1'b0;
    trapTarget     = 32'h0;
    exRedirect     = 1'b0;
    exTarget       = 32'h0;
    idValid        = 1'b0;
    idJump         = 1'b0;
    idJumpTarget   = 32'h0;
    idCall         = 1'b0;
    idRet          = 1'b0;
    idLinkAddr     = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the three strobes at once against {flushIF, flushID, rasPredict}.
  task automatic check_strobes(input string tag, input logic [2:0] exp);
    check(tag, {29'h0, flushIF, flushID, rasPredict}, {29'h0, exp});
  endtask

  initial begin
    idle();
    rst = 1'b1;
    trapValid  = 1'b1;
    trapTarget = 32'h0000_0800;
    #1;
    check_strobes("rst_strobes", 3'b000);
    step();
    step();
    check("rst_pc", pcIF, 32'h0);
    idle();
    rst = 1'b0;
    #1;

    // Free-run with 4/2/4 byte instructions.
    check("link_4", pcLink, 32'h4);
    step();
    check("seq_4", pcIF, 32'h4);
    isCompressedIF = 1'b1;
    #1;
    check("link_2", pcLink, 32'h6);
    step();
    check("seq_6", pcIF, 32'h6);
    isCompressedIF = 1'b0;
    step();
    check("seq_a", pcIF, 32'hA);

    // Trap to 0x10, then stall three cycles.
    trapValid  = 1'b1;
    trapTarget = 32'h10;
    #1;
    check_strobes("trap_strobes", 3'b110);
    step();
    check("trap_pc", pcIF, 32'h10);
    idle();
    stallIF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", pcIF, 32'h10);
    end
    stallIF = 1'b0;
    step();
    check("stall_release", pcIF, 32'h14);

    // EX redirect beats ID jump; ID call is voided.
    exRedirect   = 1'b1;
    exTarget     = 32'h201;
    idValid      = 1'b1;
    idJump       = 1'b1;
    idJumpTarget = 32'h400;
    idCall       = 1'b1;
    idLinkAddr   = 32'h999;
    #1;
    check_strobes("ex_strobes", 3'b110);
    step();
    check("ex_pc_aligned", pcIF, 32'h200);
    idle();
    idValid = 1'b1;
    idRet   = 1'b1;
    #1;
    check_strobes("ret_empty_strobes", 3'b000);
    step();
    check("ret_empty_pc", pcIF, 32'h204);

    // Unqualified ID jump is ignored.
    idle();
    idJump       = 1'b1;
    idJumpTarget = 32'h600;
    #1;
    check_strobes("idjump_invalid", 3'b000);
    step();
    check("idjump_invalid_pc", pcIF, 32'h208);

    // Trap beats EX, ignores stall.
    idle();
    trapValid  = 1'b1;
    trapTarget = 32'h800;
    exRedirect = 1'b1;
    exTarget   = 32'h300;
    stallIF    = 1'b1;
    step();
    check("trap_over_ex", pcIF, 32'h800);

    // Five calls into a four-entry stack.
    idle();
    idValid = 1'b1;
    idCall  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idLinkAddr = 32'h1000 + 32'(i) * 32'h10;
      step();
    end
    check("calls_seq_pc", pcIF, 32'h814);
    idle();
    idValid = 1'b1;
    idRet   = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      #1;
      check_strobes("ret_strobes", 3'b101);
      step();
      check("ret_predict", pcIF, 32'h1000 + 32'(i) * 32'h10);
    end
    #1;
    check_strobes("ret_exhausted", 3'b000);
    step();
    check("ret_exhausted_pc", pcIF, 32'h1014);

    // Coroutine swap: push 0x100, then call+ret with link 0x300.
    idle();
    idValid    = 1'b1;
    idCall     = 1'b1;
    idLinkAddr = 32'h100;
    step();
    check("push_pc", pcIF, 32'h1018);
    idRet      = 1'b1;
    idLinkAddr = 32'h300;
    #1;
    check_strobes("swap_strobes", 3'b101);
    step();
    check("swap_pc", pcIF, 32'h100);
    idCall = 1'b0;
    step();
    check("swap_next_ret", pcIF, 32'h300);
    #1;
    check_strobes("swap_empty", 3'b000);
    step();
    check("swap_empty_pc", pcIF, 32'h304);

    // Address wrap.
    idle();
    trapValid  = 1'b1;
    trapTarget = 32'hFFFF_FFFC;
    step();
    idle();
    #1;
    check("wrap_link", pcLink, 32'h0);
    step();
    check("wrap_pc", pcIF, 32'h0);

    // Reset mid-operation overrides a redirect.
    step();
    exRedirect = 1'b1;
    exTarget   = 32'h500;
    rst        = 1'b1;
    #1;
    check_strobes("midrst_strobes", 3'b000);
    step();
    check("midrst_pc", pcIF, 32'h0);
    rst = 1'b0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
